// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg: shared definitions for the instruction-memory boot loader.
//   state_e   : loader FSM state encoding (CHK exists only when the
//               LOADER_CHKSUM_EN macro is defined)
//   HDR_BYTES : number of header bytes carrying the word count
//   depth_f   : instruction-memory depth in words for a given address width
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int HDR_BYTES = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
`ifdef LOADER_CHKSUM_EN
      ST_CHK    = 3'd4,
`endif
      ST_FIN    = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } state_e;

   function automatic int unsigned depth_f(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if: byte-stream valid/ready handshake feeding the loader.
//   in_valid : source has a byte
//   in_data  : the byte
//   in_ready : loader can take a byte this cycle
//   master   : byte source side
//   slave    : loader side
// -----------------------------------------------------------------------------
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer: assembles accepted stream bytes into little-endian 32-bit words.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   clr_i        : session start; discards any partial word
//   byte_valid_i : a data byte was accepted this cycle
//   lane_i       : byte lane of that byte (0 = bits 7:0, 3 = bits 31:24)
//   byte_i       : the accepted byte
//   word_o       : last completed word (stable until the next one completes)
//   word_valid_o : one-cycle pulse the cycle after a lane-3 byte is accepted
// -----------------------------------------------------------------------------
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [1:0]  lane_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   // Only three bytes ever need holding: the fourth completes the word directly.
   logic [23:0] shift_q;
   logic [31:0] shift_d;
   logic [31:0] word_q;
   logic        word_valid_q;
   logic        lane3;

   assign shift_d = {byte_i, shift_q};
   assign lane3   = byte_valid_i && (lane_i == 2'd3);

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         shift_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= lane3;
         if (byte_valid_i) shift_q <= shift_d[31:8];
         if (lane3)        word_q  <= shift_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader: boot-time program loader. Receives a byte stream
// (2-byte little-endian word count, then 4*len data bytes), writes the
// assembled words sequentially into the instruction memory and holds the core
// in reset until a complete, legal image has been written.
// Optional macro LOADER_CHKSUM_EN: a trailing XOR checksum byte is required.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse, begins a session from IDLE/DONE/ERR
//   s_in         : byte-stream handshake (imem_loader_if slave)
//   mem_we/addr/wdata : instruction-memory write port (one pulse per word)
//   cpu_rst      : core reset hold, low only once an image is loaded
//   busy/done/error : session status
//   words_loaded : words written in the current/last session
// -----------------------------------------------------------------------------
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   imem_loader_if.slave      s_in,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [LEN_W-1:0]  words_loaded
);

   localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(depth_f(ADDR_W));

   state_e                   state_q, state_d;
   logic [7:0]               len_lo_q;
   logic [LEN_W-1:0]         len_q;
   logic [LEN_W+1:0]         byte_cnt_q;
   logic [LEN_W-1:0]         words_q;
   logic [ADDR_W-1:0]        addr_q;
   logic [8*HDR_BYTES-1:0]   hdr_len;
   logic [LEN_W-1:0]         hdr_len_w;
   logic                     in_ready_c;
   logic                     accept;
   logic                     sess_start;
   logic                     data_acc;
   logic                     lane3_acc;
   logic                     last_word;
   logic [31:0]              pk_word;
   logic                     pk_word_valid;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]               chk_q;
`endif

   assign accept     = s_in.in_valid && in_ready_c;
   assign sess_start = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                                 state_q == ST_ERR);
   assign hdr_len    = {s_in.in_data, len_lo_q};
   assign hdr_len_w  = LEN_W'(hdr_len);
   assign data_acc   = accept && (state_q == ST_DATA);
   assign lane3_acc  = data_acc && (byte_cnt_q[1:0] == 2'd3);
   // Word index of the byte being accepted versus the final word of the image.
   assign last_word  = (byte_cnt_q[LEN_W+1:2] == len_q - LEN_W'(1));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LEN_LO;
         ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
         ST_LEN_HI: begin
            if (accept) begin
               if (hdr_len_w == '0) begin
`ifdef LOADER_CHKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_FIN;
`endif
               end else if ({1'b0, hdr_len_w} > DEPTH_L) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (lane3_acc && last_word) begin
`ifdef LOADER_CHKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_FIN;
`endif
            end
         end
`ifdef LOADER_CHKSUM_EN
         ST_CHK: if (accept) state_d = (s_in.in_data == chk_q) ? ST_FIN : ST_ERR;
`endif
         // One idle cycle so the final memory write has retired before DONE.
         ST_FIN:  state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      in_ready_c = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_rst    = 1'b1;
      case (state_q)
         ST_LEN_LO, ST_LEN_HI, ST_DATA: begin
            in_ready_c = 1'b1;
            busy       = 1'b1;
         end
`ifdef LOADER_CHKSUM_EN
         ST_CHK: begin
            in_ready_c = 1'b1;
            busy       = 1'b1;
         end
`endif
         ST_FIN:  busy    = 1'b1;
         ST_DONE: begin
            done    = 1'b1;
            cpu_rst = 1'b0;
         end
         ST_ERR:  error   = 1'b1;
         default: ;
      endcase
   end

   assign s_in.in_ready = in_ready_c;

   // ---------------- counters and memory-port registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         len_lo_q   <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
         words_q    <= '0;
         addr_q     <= '0;
      end else if (sess_start) begin
         len_lo_q   <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
         words_q    <= '0;
      end else begin
         if (accept && state_q == ST_LEN_LO) len_lo_q <= s_in.in_data;
         if (accept && state_q == ST_LEN_HI) len_q    <= hdr_len_w;
         if (data_acc) byte_cnt_q <= byte_cnt_q + 1'b1;
         // Address and count land together with the packer's word_valid pulse.
         if (lane3_acc) begin
            addr_q  <= byte_cnt_q[ADDR_W+1:2];
            words_q <= words_q + 1'b1;
         end
      end
   end

`ifdef LOADER_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || sess_start) chk_q <= '0;
      else if (data_acc)     chk_q <= chk_q ^ s_in.in_data;
   end
`endif

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (sess_start),
      .byte_valid_i (data_acc),
      .lane_i       (byte_cnt_q[1:0]),
      .byte_i       (s_in.in_data),
      .word_o       (pk_word),
      .word_valid_o (pk_word_valid)
   );

   assign mem_we       = pk_word_valid;
   assign mem_addr     = addr_q;
   assign mem_wdata    = pk_word;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader: self-checking bench for imem_loader. Images are built in
// img_q, the expected memory contents are derived from the byte list, and the
// write port is captured by a monitor. Also usable with LOADER_CHKSUM_EN.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   localparam int ADDR_W = 8;
   localparam int LEN_W  = 16;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst, busy, done, error;
   logic [LEN_W-1:0]  words_loaded;

   imem_loader_if bus();

   imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .s_in(bus),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]        img_q[$];
   logic [7:0]        chk_corrupt = 8'h00;
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];
   int                consec_cnt = 0;
   logic              prev_we = 1'b0;

   // Write-port monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
      end
      if (mem_we === 1'b1 && prev_we === 1'b1) consec_cnt++;
      prev_we = mem_we;
   end

   function automatic logic [31:0] model_word(input int i);
      return {img_q[4*i+3], img_q[4*i+2], img_q[4*i+1], img_q[4*i]};
   endfunction

   function automatic logic [7:0] model_chk();
      logic [7:0] c = 8'h00;
      foreach (img_q[i]) c ^= img_q[i];
      return c;
   endfunction

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      consec_cnt = 0;
   endtask

   task automatic fill_img(input int nwords);
      img_q.delete();
      for (int i = 0; i < 4*nwords; i++) img_q.push_back(8'($urandom));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int guard = 0;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (bus.in_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL send_byte_timeout: in_ready=%b required 1", bus.in_ready);
      end else begin
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic load_image(input logic [15:0] nwords, input int gap);
      send_byte(nwords[7:0], gap);
      send_byte(nwords[15:8], gap);
      foreach (img_q[i]) send_byte(img_q[i], gap);
`ifdef LOADER_CHKSUM_EN
      send_byte(model_chk() ^ chk_corrupt, gap);
`endif
   endtask

   task automatic wait_end();
      int guard = 0;
      while (done !== 1'b1 && error !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (done !== 1'b1 && error !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_end_timeout: done=%b error=%b required one high", done, error);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, words_loaded, bus.in_ready}
          !== {1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_values: we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b wl=%0d rdy=%b required 0/0/0/1/0/0/0/0/0",
                  mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, words_loaded, bus.in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("reset done");
   endtask

   task automatic test_nominal();
      clear_mon();
      pulse_start();
      n_cmp++;
      if ({busy, bus.in_ready, cpu_rst} !== 3'b111) begin
         n_bad++;
         $display("FAIL nominal_start: busy/ready/cpu_rst=%b required 111", {busy, bus.in_ready, cpu_rst});
      end
      img_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      foreach (img_q[i]) send_byte(img_q[i], 0);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata, words_loaded} !== {1'b1, 8'd1, 32'h00200593, 16'd2}) begin
         n_bad++;
         $display("FAIL nominal_last_write: we=%b addr=%0d data=%h wl=%0d required 1/1/00200593/2",
                  mem_we, mem_addr, mem_wdata, words_loaded);
      end
`ifdef LOADER_CHKSUM_EN
      send_byte(model_chk(), 0);
`endif
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL nominal_done_early: done=%b required 0", done);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, cpu_rst, busy, bus.in_ready} !== 4'b1000) begin
         n_bad++;
         $display("FAIL nominal_done: done/cpu_rst/busy/ready=%b required 1000", {done, cpu_rst, busy, bus.in_ready});
      end
      n_cmp++;
      if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h00100513) begin
         n_bad++;
         $display("FAIL nominal_first_write: count=%0d required 2, first addr/data must be 0/00100513", wr_addr_q.size());
      end
      $display("nominal load checked, words_loaded=%0d", words_loaded);
   endtask

   task automatic test_zero_len();
      clear_mon();
      pulse_start();
      img_q.delete();
      load_image(16'd0, 0);
      @(negedge clk);
      n_cmp++;
      if ({done, cpu_rst, error, words_loaded} !== {1'b1, 1'b0, 1'b0, 16'd0} || wr_addr_q.size() != 0) begin
         n_bad++;
         $display("FAIL zero_len: done=%b cpu_rst=%b err=%b wl=%0d writes=%0d required 1/0/0/0/0",
                  done, cpu_rst, error, words_loaded, wr_addr_q.size());
      end
      $display("zero-length load checked");
   endtask

   task automatic test_oversize();
      clear_mon();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({error, done, bus.in_ready, cpu_rst, busy} !== 5'b10010 || wr_addr_q.size() != 0) begin
         n_bad++;
         $display("FAIL oversize: err/done/ready/cpu_rst/busy=%b writes=%0d required 10010/0",
                  {error, done, bus.in_ready, cpu_rst, busy}, wr_addr_q.size());
      end
      $display("oversize header checked");
   endtask

   task automatic test_gappy();
      logic [31:0] ref_data[$];
      fill_img(3);
      for (int pass = 0; pass < 2; pass++) begin
         clear_mon();
         pulse_start();
         load_image(16'd3, (pass == 0) ? 0 : 50);
         wait_end();
         n_cmp++;
         if (done !== 1'b1 || words_loaded !== 16'd3 || wr_addr_q.size() != 3 || consec_cnt != 0) begin
            n_bad++;
            $display("FAIL gappy_status pass%0d: done=%b wl=%0d writes=%0d consec=%0d required 1/3/3/0",
                     pass, done, words_loaded, wr_addr_q.size(), consec_cnt);
         end else begin
            for (int i = 0; i < 3; i++) begin
               n_cmp++;
               if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== model_word(i)) begin
                  n_bad++;
                  $display("FAIL gappy_write pass%0d[%0d]: addr=%0d data=%h required %0d/%h",
                           pass, i, wr_addr_q[i], wr_data_q[i], i, model_word(i));
               end
               if (pass == 0) ref_data.push_back(wr_data_q[i]);
               else begin
                  n_cmp++;
                  if (wr_data_q[i] !== ref_data[i]) begin
                     n_bad++;
                     $display("FAIL gappy_vs_b2b[%0d]: data=%h required %h", i, wr_data_q[i], ref_data[i]);
                  end
               end
            end
         end
         $display("3-word load pass %0d checked", pass);
      end
   endtask

   task automatic test_start_ignored();
      clear_mon();
      fill_img(1);
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(img_q[0], 0);
      send_byte(img_q[1], 0);
      pulse_start();
      send_byte(img_q[2], 0);
      send_byte(img_q[3], 0);
`ifdef LOADER_CHKSUM_EN
      send_byte(model_chk(), 0);
`endif
      wait_end();
      n_cmp++;
      if (done !== 1'b1 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== model_word(0)) begin
         n_bad++;
         $display("FAIL start_ignored: done=%b writes=%0d required done 1, one write of %h at 0",
                  done, wr_addr_q.size(), model_word(0));
      end
      $display("mid-session start checked");
   endtask

   task automatic test_reset_mid();
      clear_mon();
      fill_img(2);
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 6; i++) send_byte(img_q[i], 0);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, words_loaded, bus.in_ready}
          !== {1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_mid_values: we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b wl=%0d rdy=%b required 0/0/0/1/0/0/0/0/0",
                  mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, words_loaded, bus.in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (wr_addr_q.size() != 1) begin
         n_bad++;
         $display("FAIL reset_mid_writes: writes=%0d required 1", wr_addr_q.size());
      end
      clear_mon();
      fill_img(1);
      pulse_start();
      load_image(16'd1, 20);
      wait_end();
      n_cmp++;
      if (done !== 1'b1 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== model_word(0)) begin
         n_bad++;
         $display("FAIL reset_mid_reload: done=%b writes=%0d required done 1, one write of %h at 0",
                  done, wr_addr_q.size(), model_word(0));
      end
      $display("reset mid-word checked");
   endtask

   task automatic test_full_depth();
      clear_mon();
      fill_img(DEPTH);
      pulse_start();
      load_image(16'(DEPTH), 0);
      wait_end();
      n_cmp++;
      if (done !== 1'b1 || words_loaded !== 16'(DEPTH) || wr_addr_q.size() != DEPTH || consec_cnt != 0) begin
         n_bad++;
         $display("FAIL full_depth_status: done=%b wl=%0d writes=%0d consec=%0d required 1/%0d/%0d/0",
                  done, words_loaded, wr_addr_q.size(), consec_cnt, DEPTH, DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== model_word(i)) begin
               n_bad++;
               $display("FAIL full_depth_write[%0d]: addr=%0d data=%h required %0d/%h",
                        i, wr_addr_q[i], wr_data_q[i], i, model_word(i));
            end
         end
      end
      $display("full-depth load checked");
   endtask

`ifdef LOADER_CHKSUM_EN
   task automatic test_chksum();
      img_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int bad = 0; bad < 2; bad++) begin
         clear_mon();
         chk_corrupt = (bad == 1) ? 8'h01 : 8'h00;
         pulse_start();
         load_image(16'd1, 0);
         wait_end();
         n_cmp++;
         if ({done, error, cpu_rst} !== ((bad == 1) ? 3'b011 : 3'b100)) begin
            n_bad++;
            $display("FAIL chksum_status bad=%0d: done/err/cpu_rst=%b", bad, {done, error, cpu_rst});
         end
         n_cmp++;
         if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h44332211) begin
            n_bad++;
            $display("FAIL chksum_write bad=%0d: writes=%0d required one write of 44332211 at 0",
                     bad, wr_addr_q.size());
         end
         $display("checksum case bad=%0d checked", bad);
      end
      chk_corrupt = 8'h00;
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_zero_len();
      test_oversize();
      test_gappy();
      test_start_ignored();
      test_reset_mid();
      test_full_depth();
`ifdef LOADER_CHKSUM_EN
      test_chksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into the instruction memory's write port. It also holds the core in reset (cpu_rst) until a complete, legal image has been written; it is the writer side of the instruction memory that the core only reads.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
LEN_W, 16, width of the word-count header field (fixed two bytes on the stream)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a load session
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  word written
cpu_rst  output  1  core reset hold; high while image not valid
busy  output  1  session in progress
done  output  1  image loaded successfully (level)
error  output  1  session aborted (level)
words_loaded  output  LEN_W  words written in the current/last session

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high; all state is updated on the rising edge of clk.
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 1, busy 0, done 0, error 0, words_loaded 0, byte counter 0.
- Transfer: a byte is accepted only when in_valid && in_ready at a rising edge; in_data is ignored otherwise.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK (macro only), FIN, DONE, ERR.
- IDLE/DONE/ERR + start: go to LEN_LO, clear done/error/words_loaded/byte counter, busy=1, cpu_rst=1. start is ignored in every other state.
- LEN_LO: accepted byte -> len[7:0]. LEN_HI: accepted byte -> len[15:8].
- Length check, evaluated on the LEN_HI acceptance:
  - len==0 -> FIN.
  - len>DEPTH -> ERR.
  - otherwise -> DATA.
- DATA, byte packing: byte lane = byte_cnt[1:0]; lane 0 goes to bits [7:0] and lane 3 to bits [31:24].
- DATA, word write: on acceptance of lane 3 at cycle T, mem_we=1 at T+1 with mem_addr=word index (0-based) and mem_wdata=assembled word. words_loaded increments at T+1. mem_we is never high for two consecutive cycles.
- DATA exit: after the lane-3 byte of word len-1 is accepted, go to CHK if the macro is defined, else FIN.
- in_ready: 1 in LEN_LO, LEN_HI, DATA, CHK; 0 elsewhere, including FIN/DONE/ERR/IDLE.
- Back-to-back bytes: the next word's lane 0 may be accepted in the same cycle as the previous word's mem_we.
- FIN: lasts one cycle, so the final write has retired; then DONE.
- DONE: done=1, busy=0, cpu_rst=0.
- ERR: error=1, busy=0, cpu_rst=1, no further writes.
- Address wrap is impossible: len is bounded by DEPTH, so mem_addr never exceeds DEPTH-1.
- Reset mid-session: the partial word is discarded, nothing else is written, and the outputs return to their reset values next cycle.
- Stalls: the stream may stall indefinitely (in_valid low); there is no timeout.

Optional Feature:
LOADER_CHKSUM_EN
- With LOADER_CHKSUM_EN defined:
  - After the last data byte, the CHK state accepts one byte.
  - That byte must equal the XOR of all 4*len data bytes (header excluded). For len==0 the expected value is 0x00, and LEN_HI goes to CHK instead of FIN.
  - Match -> FIN -> DONE. Mismatch -> ERR.
  - Words already written stay in memory, but cpu_rst stays high.
- Without it: no CHK state; the data phase goes directly to FIN.

Decomposition:
- Package loader_pkg holds:
  - the state encoding enum;
  - constant HDR_BYTES=2;
  - a DEPTH function of ADDR_W.
- One natural sub-module, byte_packer:
  - shifts accepted bytes into a 32-bit register;
  - emits word_valid for one cycle after lane 3;
  - clears on session start or rst.
- The FSM, counters and memory-port registers stay in imem_loader.

Test Plan:
- Nominal load: rst, start, stream 02 00 | 13 05 10 00 | 93 05 20 00 -> mem_we at addr 0 data 0x00100513, then addr 1 data 0x00200593; words_loaded=2; done=1 and cpu_rst=0 two cycles after the last byte.
- Zero length: start, stream 00 00 -> no mem_we, done=1, cpu_rst=0 (with macro: send checksum 00 first).
- Oversize: ADDR_W=8, header 01 01 (257) -> error=1, in_ready=0, cpu_rst=1, no mem_we.
- Gappy stream: in_valid toggled randomly, 3 words -> identical writes and addresses as back-to-back; mem_we never on consecutive cycles.
- Reset mid-word: rst after 2 data bytes of word 1 -> all outputs at reset values; subsequent full reload of 1 word writes addr 0 correctly.
- LOADER_CHKSUM_EN: 1 word 11 22 33 44 with checksum 44 -> done=1. Same word with checksum 45 -> error=1, cpu_rst=1, and addr 0 holds 0x44332211.
